// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states and the
// registered request record.
package dmem_pkg;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   localparam int unsigned REQ_ADDR_W = 32;
   localparam int unsigned REQ_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [2:0]            size;
      logic                  is_unsigned;
   } req_t;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational alignment/size check for a data-memory access; also used by
// the core's trap logic.
import dmem_pkg::*;

module dmem_align_chk (
   input  logic [1:0] addr_lo,
   input  logic [2:0] size,
   output logic       err
);

   always_comb begin
      err = 1'b0;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = addr_lo[0];
         SZ_WORD: err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port: port 0 (core MEM
// stage) has priority, port 1 (loader/debug) is guaranteed a grant after MAX_WAIT losses.
import dmem_pkg::*;

module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_write,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   input  logic [5:0]            req_size,
   input  logic [1:0]            req_unsigned,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_load_type,
   output logic                  mem_load_unsigned,
   output logic                  mem_write,
   output logic [2:0]            mem_store_type,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   state_t            state, state_nxt;
   req_t              req_q;
   logic              owner_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              grant_vld;
   logic              grant_port;
   logic              access_err;
   req_t              grant_req;

   dmem_align_chk u_align_chk (
      .addr_lo (req_q.addr[1:0]),
      .size    (req_q.size),
      .err     (access_err)
   );

   // Grants only in IDLE; reset masks the grant so nothing is accepted while rst is high.
   always_comb begin
      grant_vld  = 1'b0;
      grant_port = 1'b0;
      if (state == IDLE && !rst) begin
         if (req_valid[1] && wait_cnt == WAIT_W'(MAX_WAIT)) begin
            grant_vld  = 1'b1;
            grant_port = 1'b1;
         end else if (req_valid[0]) begin
            grant_vld  = 1'b1;
         end else if (req_valid[1]) begin
            grant_vld  = 1'b1;
            grant_port = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = 2'b00;
      if (grant_vld) req_ready[grant_port] = 1'b1;
   end

   always_comb begin
      grant_req.write       = grant_port ? req_write[1]              : req_write[0];
      grant_req.addr        = grant_port ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      grant_req.wdata       = grant_port ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      grant_req.size        = grant_port ? req_size[5:3]              : req_size[2:0];
      grant_req.is_unsigned = grant_port ? req_unsigned[1]            : req_unsigned[0];
   end

   always_comb begin
      state_nxt = state;
      rsp_valid = 2'b00;
      mem_write = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_write = req_q.write & ~access_err;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side outputs come straight from the request register, which only
   // changes on a grant, so they hold their last values outside ACCESS.
   assign mem_addr          = req_q.addr;
   assign mem_wdata         = req_q.wdata;
   assign mem_load_type     = req_q.size;
   assign mem_store_type    = req_q.size;
   assign mem_load_unsigned = req_q.is_unsigned;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_q     <= '0;
         owner_q   <= 1'b0;
         wait_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_vld) begin
            req_q   <= grant_req;
            owner_q <= grant_port;
         end
         if (state == ACCESS) begin
            rsp_rdata <= (req_q.write | access_err) ? '0 : mem_rdata;
            rsp_err   <= access_err;
         end
         if (!req_valid[1] || (grant_vld && grant_port)) begin
            wait_cnt <= '0;
         end else if (state == IDLE && wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule
